// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Instruction fetch sequencer for a single-ported instruction ROM with one
// cycle of read latency. It owns the fetch PC, issues ROM reads, and tracks
// which PC the word on the ROM data output belongs to. Redirects come from
// branch, jump or exception logic. A fetch from an address that is misaligned
// or outside the ROM parks the unit in HALT with a sticky fault. Only reset
// leaves HALT.
//
// Parameters
//   RESET_PC        byte address of the first instruction fetched after reset
//   IM_WORDS        number of 32-bit words in the instruction ROM
//
// Ports
//   clk             sole clock, rising edge
//   rst             synchronous, active-high reset; overrides all other inputs
//   stall           downstream cannot accept; fetch state is held
//   redirect_valid  redirect request this cycle; takes priority over stall
//   redirect_target byte address to fetch from after the redirect
//   im_ce           ROM read enable
//   im_addr         ROM word address (fetch_pc[15:2])
//   if_pc           PC of the word currently on the ROM data output
//   if_pc4          if_pc + 4
//   if_valid        ROM data output holds a live instruction for if_pc
//   fetch_fault     sticky fault: misaligned or out-of-range fetch
//   fault_pc        address that raised fetch_fault
//   fetch_count     ROM reads issued since reset, wraps modulo 2^32
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        im_ce,
    output logic [13:0] im_addr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic        if_valid,
    output logic        fetch_fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    // The bounds are 33 bits wide so that a ROM ending at 2^32 does not wrap.
    // A fetch_pc that wraps past 0xFFFF_FFFC then lands below RANGE_LO and
    // is caught as out of range.
    localparam logic [32:0] RANGE_LO = {1'b0, RESET_PC};
    localparam logic [32:0] RANGE_HI = {1'b0, RESET_PC} + (33'(IM_WORDS) << 2);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state,       state_n;
    logic [31:0] fetch_pc,    fetch_pc_n;
    logic [31:0] if_pc_n;
    logic        if_valid_n;
    logic        fetch_fault_n;
    logic [31:0] fault_pc_n;
    logic [31:0] fetch_count_n;
    logic        in_range;

    assign in_range = ({1'b0, fetch_pc} >= RANGE_LO) &&
                      ({1'b0, fetch_pc} <  RANGE_HI) &&
                      (fetch_pc[1:0] == 2'b00);

    assign im_addr = fetch_pc[15:2];
    assign if_pc4  = if_pc + 32'd4;

    // A read issues only when it would complete: running, not in reset, not
    // stalled, not being redirected, and the address is legal. Stalling with
    // im_ce low is also what holds the ROM output steady.
    assign im_ce = (state == RUN) && !rst && !stall && !redirect_valid && in_range;

    // Next-state and next-register logic.
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so
        // no path leaves a value unassigned and no latch is inferred.
        state_n       = state;
        fetch_pc_n    = fetch_pc;
        if_pc_n       = if_pc;
        if_valid_n    = if_valid;
        fetch_fault_n = fetch_fault;
        fault_pc_n    = fault_pc;
        fetch_count_n = fetch_count;

        unique case (state)
            RUN: begin
                if (redirect_valid) begin
                    // The word in flight belongs to the old path, so kill it.
                    fetch_pc_n = redirect_target;
                    if_valid_n = 1'b0;
                end else if (!stall) begin
                    if (in_range) begin
                        fetch_pc_n    = fetch_pc + 32'd4;
                        if_pc_n       = fetch_pc;
                        if_valid_n    = 1'b1;
                        fetch_count_n = fetch_count + 32'd1;
                    end else begin
                        // The fault is raised only when a fetch would
                        // actually issue, never while stalled.
                        state_n       = HALT;
                        fetch_fault_n = 1'b1;
                        fault_pc_n    = fetch_pc;
                        if_valid_n    = 1'b0;
                    end
                end
            end
            HALT: begin
                if_valid_n = 1'b0;
            end
        endcase
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments, so all of them
        // update together from values computed before the edge.
        if (rst) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            if_pc       <= RESET_PC;
            if_valid    <= 1'b0;
            fetch_fault <= 1'b0;
            fault_pc    <= 32'd0;
            fetch_count <= 32'd0;
        end else begin
            state       <= state_n;
            fetch_pc    <= fetch_pc_n;
            if_pc       <= if_pc_n;
            if_valid    <= if_valid_n;
            fetch_fault <= fetch_fault_n;
            fault_pc    <= fault_pc_n;
            fetch_count <= fetch_count_n;
        end
    end

endmodule
